// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift-out, ACK check.
// Optional PS2_TX_RETRY_EN: one automatic retry of the same byte on NACK or timeout.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 2600,
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error,
    output logic       rx_inhibit
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ACK,
        S_DONE
    } state_t;

    state_t state, state_next, fail_state;

    logic [SYNC_STAGES-1:0] clk_sh, dat_sh;
    logic                   clk_s, dat_s, clk_prev, fe;

    logic [7:0]       data_q;
    logic             par_q;
    logic [2:0]       bit_idx;
    logic             ack_q;
    logic             dat_oe_q;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             inh_last, active, timeout;

    // idle bus level is high, so the synchronizers reset to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sh   <= '1;
            dat_sh   <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sh   <= {clk_sh[SYNC_STAGES-2:0], ps2_clk_in};
            dat_sh   <= {dat_sh[SYNC_STAGES-2:0], ps2_dat_in};
            clk_prev <= clk_s;
        end
    end

    assign clk_s    = clk_sh[SYNC_STAGES-1];
    assign dat_s    = dat_sh[SYNC_STAGES-1];
    assign fe       = clk_prev & ~clk_s;
    assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign active   = (state == S_REQUEST) || (state == S_DATA) ||
                      (state == S_PARITY)  || (state == S_STOP) ||
                      (state == S_ACK);
    assign timeout  = active && (to_cnt == TO_W'(TIMEOUT_CYCLES));

`ifdef PS2_TX_RETRY_EN
    logic retry_q;
    assign fail_state = retry_q ? S_DONE : S_INHIBIT;
`else
    assign fail_state = S_DONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (tx_start) state_next = S_INHIBIT;
            S_INHIBIT: if (inh_last) state_next = S_REQUEST;
            S_REQUEST: if (fe) state_next = S_DATA;
            S_DATA:    if (fe && bit_idx == 3'd0) state_next = S_PARITY;
            S_PARITY:  if (fe) state_next = S_STOP;
            S_STOP:    if (fe) state_next = S_ACK;
            S_ACK:     if (clk_s && dat_s)
                           state_next = ack_q ? S_DONE : fail_state;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (timeout) state_next = fail_state;
    end

    always_comb begin
        tx_ready   = (state == S_IDLE);
        ps2_clk_oe = (state == S_INHIBIT);
        tx_done    = (state == S_DONE);
        tx_ack_ok  = (state == S_DONE) & ack_q;
        tx_error   = (state == S_DONE) & ~ack_q;
        rx_inhibit = (state != S_IDLE);
    end

    assign ps2_dat_oe = dat_oe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (state != S_INHIBIT || state_next != S_INHIBIT)
                inh_cnt <= '0;
            else
                inh_cnt <= inh_cnt + 1'b1;
            if (fe || state_next != state || !active)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            par_q    <= 1'b0;
            bit_idx  <= '0;
            ack_q    <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    dat_oe_q <= 1'b0;
                    bit_idx  <= '0;
                    if (tx_start) begin
                        data_q <= tx_data;
                        par_q  <= ~^tx_data;
                        ack_q  <= 1'b0;
                    end
                end
                S_INHIBIT: if (inh_last) dat_oe_q <= 1'b1;
                S_REQUEST: if (fe) begin
                    dat_oe_q <= ~data_q[0];
                    bit_idx  <= 3'd1;
                end
                // bit_idx wraps to 0 once bit7 is on the line
                S_DATA: if (fe) begin
                    if (bit_idx != 3'd0) begin
                        dat_oe_q <= ~data_q[bit_idx];
                        bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        dat_oe_q <= ~par_q;
                    end
                end
                S_PARITY: if (fe) dat_oe_q <= 1'b0;
                S_STOP:   if (fe) ack_q <= ~dat_s;
                default: ;
            endcase
            if (timeout) begin
                dat_oe_q <= 1'b0;
                ack_q    <= 1'b0;
            end
            if (state != S_IDLE && state != S_INHIBIT &&
                state_next == S_INHIBIT) begin
                dat_oe_q <= 1'b0;
                bit_idx  <= '0;
            end
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retry_q <= 1'b0;
        else if (state == S_IDLE && tx_start)
            retry_q <= 1'b0;
        else if (state != S_IDLE && state != S_INHIBIT &&
                 state_next == S_INHIBIT)
            retry_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain PS/2 device model.
module tb_ps2_tx;

    localparam int INH = 2600;
    localparam int TO  = 2000;
    localparam int H   = 15;

    logic       clk, rst;
    logic       dev_clk, dev_dat;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready, tx_done, tx_ack_ok, tx_error, rx_inhibit;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_ack_ok(tx_ack_ok),
        .tx_error(tx_error),
        .rx_inhibit(rx_inhibit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (tx_done) done_count <= done_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic measure_inhibit();
        int n = 0;
        int w = 0;
        while (!ps2_clk_oe && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("inh_seen", {31'd0, ps2_clk_oe}, 32'd1);
        chk("inh_dat_rel", {31'd0, ps2_dat_oe}, 32'd0);
        while (ps2_clk_oe && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("inh_len", n, INH);
        chk("req_start", {31'd0, ps2_dat_oe}, 32'd1);
        chk("req_rx_inh", {31'd0, rx_inhibit}, 32'd1);
    endtask

    task automatic frame(input logic nack, input int npulses,
                         output logic [10:0] bits);
        bits = '0;
        repeat (20) @(negedge clk);
        chk("start_bit", {31'd0, ps2_dat_in}, 32'd0);
        for (int k = 0; k < npulses; k++) begin
            if (k == 10) begin
                dev_dat = nack;
                repeat (3) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            bits[k] = ps2_dat_in;
            dev_clk = 1'b1;
            if (k == 10) dev_dat = 1'b1;
            if (k < npulses - 1) repeat (H) @(negedge clk);
        end
    endtask

    task automatic wait_done(input logic exp_ok);
        int w = 0;
        while (!tx_done && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", {31'd0, tx_done}, 32'd1);
        chk("ack_ok", {31'd0, tx_ack_ok}, {31'd0, exp_ok});
        chk("error", {31'd0, tx_error}, {31'd0, ~exp_ok});
        chk("done_rx_inh", {31'd0, rx_inhibit}, 32'd1);
        @(negedge clk);
        chk("ready_after", {31'd0, tx_ready}, 32'd1);
        chk("rx_inh_after", {31'd0, rx_inhibit}, 32'd0);
    endtask

    task automatic run_ok(input logic [7:0] b, input logic exp_par);
        logic [10:0] bits;
        do_start(b);
        measure_inhibit();
        frame(1'b0, 11, bits);
        chk("byte", {24'd0, bits[7:0]}, {24'd0, b});
        chk("parity", {31'd0, bits[8]}, {31'd0, exp_par});
        chk("stop", {31'd0, bits[9]}, 32'd1);
        chk("ack_line", {31'd0, bits[10]}, 32'd0);
        wait_done(1'b1);
    endtask

    initial begin
        logic [10:0] bits;
        int n;
        int dc;
        rst      = 1'b1;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        #2;
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_ack_err", {30'd0, tx_ack_ok, tx_error}, 32'd0);
        chk("rst_rx_inh", {31'd0, rx_inhibit}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: line bits 1,0,1,1,0,1,1,1 then parity 1
        run_ok(8'hED, 1'b1);

        // 0x01 with a stray 0xAA request while busy
        dc = done_count;
        do_start(8'h01);
        measure_inhibit();
        @(negedge clk);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        chk("busy_ready", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        tx_start = 1'b0;
        frame(1'b0, 11, bits);
        chk("byte_01", {24'd0, bits[7:0]}, 32'h01);
        chk("parity_01", {31'd0, bits[8]}, 32'd0);
        wait_done(1'b1);
        repeat (50) @(negedge clk);
        chk("single_done", done_count - dc, 1);
        chk("idle_ready", {31'd0, tx_ready}, 32'd1);

        run_ok(8'h00, 1'b1);
        run_ok(8'hFF, 1'b1);

        // NACK on the 11th clock
        dc = done_count;
        do_start(8'hF4);
        measure_inhibit();
        frame(1'b1, 11, bits);
        chk("byte_f4", {24'd0, bits[7:0]}, 32'hF4);
        chk("nack_line", {31'd0, bits[10]}, 32'd1);
`ifdef PS2_TX_RETRY_EN
        measure_inhibit();
        chk("no_done_yet", done_count - dc, 0);
        frame(1'b0, 11, bits);
        chk("retry_byte", {24'd0, bits[7:0]}, 32'hF4);
        wait_done(1'b1);
`else
        wait_done(1'b0);
`endif
        chk("nack_one_done", done_count - dc, 1);

        // device never clocks
        do_start(8'h55);
        measure_inhibit();
`ifdef PS2_TX_RETRY_EN
        n = 0;
        while (!ps2_clk_oe && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        measure_inhibit();
`endif
        n = 0;
        while (!tx_done && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_time", {31'd0, (n >= TO && n <= TO + 2)}, 32'd1);
        chk("to_done", {31'd0, tx_done}, 32'd1);
        chk("to_error", {31'd0, tx_error}, 32'd1);
        chk("to_ack", {31'd0, tx_ack_ok}, 32'd0);
        chk("to_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        @(negedge clk);
        chk("to_ready", {31'd0, tx_ready}, 32'd1);

        // async reset during data bit 4 (0x00 keeps data pulled low)
        do_start(8'h00);
        measure_inhibit();
        frame(1'b0, 5, bits);
        repeat (3) @(negedge clk);
        chk("pre_rst_dat", {31'd0, ps2_dat_oe}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        chk("arst_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (H) @(negedge clk);
        run_ok(8'hFF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter, the outbound counterpart of the ps2 keyboard receiver. Sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It follows the host-request sequence: inhibit the clock, issue the request-to-send, shift out bits on device-generated clock edges, then check the device ACK. It shares the ps2_clk/ps2_dat pads with the receiver through open-drain enables in the top level and runs in the clk_25M175 domain.

Parameters:
INHIBIT_CYCLES, 2600, cycles ps2_clk is held low before request (≥100 µs at 25.175 MHz)
TIMEOUT_CYCLES, 400000, max cycles between device clock falling edges, and from request to first edge (~15.9 ms)
SYNC_STAGES, 2, synchronizer flops on ps2_clk_in and ps2_dat_in (≥2)

Ports:
clk  input  1  system clock (clk_25M175)
rst  input  1  asynchronous active-high reset
ps2_clk_in  input  1  raw PS/2 clock pad level
ps2_dat_in  input  1  raw PS/2 data pad level
ps2_clk_oe  output  1  1 = pull ps2_clk low, 0 = release
ps2_dat_oe  output  1  1 = pull ps2_dat low, 0 = release
tx_data  input  8  byte to send, sampled on accept
tx_start  input  1  request; accepted when tx_ready=1
tx_ready  output  1  idle and able to accept
tx_done  output  1  one-cycle pulse at end of transfer
tx_ack_ok  output  1  valid with tx_done: device ACKed
tx_error  output  1  valid with tx_done: timeout or NACK
rx_inhibit  output  1  high while busy; receiver must ignore the line

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, tx_done=0, tx_ack_ok=0, tx_error=0, rx_inhibit=0, FSM=IDLE. Asserting rst mid-transfer releases both lines immediately, with no clock needed.
- Edge detection: inputs pass through SYNC_STAGES flops. A falling edge (fe) is registered sync_prev=1 and sync=0.
- Timeout counter: clears on every fe and on each state entry. It runs in REQUEST through ACK.
- Framing: 11 bits. Start=0, then data LSB first, then odd parity (parity = ~^tx_data), then stop = released (1).
- IDLE:
  - tx_ready=1.
  - tx_start & tx_ready: latch tx_data, compute parity, go to INHIBIT next cycle.
  - tx_start while not ready is ignored.
- INHIBIT:
  - ps2_clk_oe=1, ps2_dat_oe=0, for exactly INHIBIT_CYCLES cycles.
  - Then, in the same cycle edge: ps2_dat_oe=1 (start bit) and ps2_clk_oe=0. Go to REQUEST.
- REQUEST:
  - Wait for the first fe; this is the device clocking out the start bit.
  - On that fe, drive data bit0 (ps2_dat_oe = ~bit0). Go to DATA, bit index 1.
- DATA:
  - Each fe drives the next bit, through bit7.
  - The fe after bit7 is driven presents parity. Go to PARITY.
- PARITY: the next fe releases the line (ps2_dat_oe=0, the stop bit). Go to STOP.
- STOP: the next fe samples synchronized data and goes to ACK.
  - Data 0 means ACK: set ack flag.
  - Data 1 means NACK.
- ACK:
  - Wait until synchronized clk=1 and dat=1, the bus-idle condition.
  - Then tx_done=1 for one cycle, with tx_ack_ok = ack flag and tx_error = ~ack flag. Return to IDLE.
  - tx_ready rises the cycle after tx_done.
- Timeout: counter reaching TIMEOUT_CYCLES in REQUEST..ACK triggers:
  - both oe=0 in the next cycle;
  - tx_done pulse with tx_error=1, tx_ack_ok=0;
  - FSM to IDLE.
- rx_inhibit: 1 in every state except IDLE, including the tx_done cycle.
- Data line: ps2_dat_oe changes only on fe or on INHIBIT exit, never mid-bit.
- ps2_clk_oe is asserted only in INHIBIT.
- Bit counter: 3 bits. Parity register: 1 bit. Inhibit counter: $clog2(INHIBIT_CYCLES+1). Timeout counter: $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
PS2_TX_RETRY_EN
- Defined:
  - On NACK or timeout, the block retries the same byte once automatically, restarting at INHIBIT with tx_done suppressed.
  - tx_done is reported after the second attempt only.
  - A 1-bit retry flag clears on accept.
- Undefined: a single attempt; failure is reported directly in tx_done/tx_error.

Test Plan:
- Send 0xED, device model ACKs. Required response:
  - ps2_clk_oe high for exactly 2600 cycles.
  - Line bits after the start bit: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done with tx_ack_ok=1, tx_error=0; rx_inhibit low afterwards.
- Send 0x01: parity bit 0. Send 0x00: parity bit 1. Send 0xFF: parity 1. Device-sampled byte must match tx_data in each case.
- Device holds data high on the 11th clock (NACK). Required response:
  - Without the macro: tx_done with tx_error=1, tx_ack_ok=0.
  - With PS2_TX_RETRY_EN: a second full frame is sent, then a single tx_done.
- Device never clocks after the request. Required response:
  - After 400000 cycles, both oe=0, tx_done with tx_error=1.
  - tx_ready=1 on the next cycle.
- Assert rst during DATA bit 4. Required response:
  - ps2_clk_oe and ps2_dat_oe are 0 asynchronously, before the next clk edge; tx_ready=1.
  - A new 0xFF send then completes normally.
- Pulse tx_start during an active transfer with tx_data=0xAA. Required response:
  - It is ignored; the in-flight byte is unchanged.
  - Exactly one tx_done results.
